// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 unified memory port arbiter.
// Holds the FSM state encoding, the GRANT encodings and the default bus widths.
package rv32_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/timeout_counter.sv
// Saturating wait counter for an active memory grant.
// expired is high while the count equals TIMEOUT; the count stops there and never wraps.
module timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store,
// with round-robin tie-breaking, a per-grant timeout and registered responses.
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                I_REQ,
  input  logic [ADDR_W-1:0]   I_ADDR,
  output logic [DATA_W-1:0]   I_RDATA,
  output logic                I_ACK,
  output logic                I_ERR,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [DATA_W/8-1:0] D_WSTRB,
  input  logic [ADDR_W-1:0]   D_ADDR,
  input  logic [DATA_W-1:0]   D_WDATA,
  output logic [DATA_W-1:0]   D_RDATA,
  output logic                D_ACK,
  output logic                D_ERR,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [DATA_W/8-1:0] MEM_WSTRB,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_WDATA,
  input  logic [DATA_W-1:0]   MEM_RDATA,
  input  logic                MEM_ACK,
  output logic                STALL,
  output logic [1:0]          GRANT,
  output logic [1:0]          dbg_state
);

  // Handshake: every *_REQ is held with stable payload until its *_ACK pulse;
  // ACK lasts one cycle and ERR is meaningful only while ACK is high.

  arb_state_t state, state_nx;
  logic       last_gnt_d;
  logic       grant_i, grant_d, done_ok, done_to;
  logic       expired;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    case (state)
      ST_IDLE: begin
        // On a tie, the requester that was not served last wins.
        if (I_REQ && (!D_REQ || last_gnt_d)) begin
          grant_i  = 1'b1;
          state_nx = ST_GNT_I;
        end else if (D_REQ) begin
          grant_d  = 1'b1;
          state_nx = ST_GNT_D;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (MEM_ACK) begin
          done_ok  = 1'b1;
          state_nx = ST_RESP;
        end else if (expired) begin
          done_to  = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clear   (grant_i | grant_d),
    .enable  ((state == ST_GNT_I) || (state == ST_GNT_D)),
    .expired (expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_REQ    <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_WSTRB  <= '0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      I_RDATA    <= '0;
      D_RDATA    <= '0;
      I_ACK      <= 1'b0;
      I_ERR      <= 1'b0;
      D_ACK      <= 1'b0;
      D_ERR      <= 1'b0;
      GRANT      <= GRANT_NONE;
      last_gnt_d <= 1'b1;
    end else begin
      I_ACK <= 1'b0;
      I_ERR <= 1'b0;
      D_ACK <= 1'b0;
      D_ERR <= 1'b0;
      if (grant_i) begin
        MEM_REQ   <= 1'b1;
        MEM_WE    <= 1'b0;
        MEM_WSTRB <= '0;
        MEM_ADDR  <= I_ADDR;
        MEM_WDATA <= '0;
        GRANT     <= GRANT_I;
      end
      if (grant_d) begin
        MEM_REQ   <= 1'b1;
        MEM_WE    <= D_WE;
        MEM_WSTRB <= D_WSTRB;
        MEM_ADDR  <= D_ADDR;
        MEM_WDATA <= D_WDATA;
        GRANT     <= GRANT_D;
      end
      // A timeout reports ERR and leaves the requester's RDATA untouched.
      if (done_ok || done_to) begin
        MEM_REQ    <= 1'b0;
        GRANT      <= GRANT_NONE;
        last_gnt_d <= (state == ST_GNT_D);
        if (state == ST_GNT_D) begin
          D_ACK <= 1'b1;
          D_ERR <= done_to;
          if (done_ok) D_RDATA <= MEM_RDATA;
        end else begin
          I_ACK <= 1'b1;
          I_ERR <= done_to;
          if (done_ok) I_RDATA <= MEM_RDATA;
        end
      end
    end
  end

  assign STALL     = (I_REQ & ~I_ACK) | (D_REQ & ~D_ACK);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4 and hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GNTI = 2'd1;
  localparam logic [1:0] S_RESP = 2'd3;

  logic                CLK, RST_N;
  logic                I_REQ;
  logic [ADDR_W-1:0]   I_ADDR;
  logic [DATA_W-1:0]   I_RDATA;
  logic                I_ACK, I_ERR;
  logic                D_REQ, D_WE;
  logic [DATA_W/8-1:0] D_WSTRB;
  logic [ADDR_W-1:0]   D_ADDR;
  logic [DATA_W-1:0]   D_WDATA, D_RDATA;
  logic                D_ACK, D_ERR;
  logic                MEM_REQ, MEM_WE;
  logic [DATA_W/8-1:0] MEM_WSTRB;
  logic [ADDR_W-1:0]   MEM_ADDR;
  logic [DATA_W-1:0]   MEM_WDATA, MEM_RDATA;
  logic                MEM_ACK;
  logic                STALL;
  logic [1:0]          GRANT;
  logic [1:0]          dbg_state;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK), .I_ERR(I_ERR),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_WSTRB(D_WSTRB), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_RDATA(D_RDATA), .D_ACK(D_ACK), .D_ERR(D_ERR),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_WSTRB(MEM_WSTRB), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .STALL(STALL), .GRANT(GRANT), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    RST_N = 1'b0; I_REQ = 1'b0; I_ADDR = '0;
    D_REQ = 1'b0; D_WE = 1'b0; D_WSTRB = '0; D_ADDR = '0; D_WDATA = '0;
    MEM_RDATA = '0; MEM_ACK = 1'b0;
    #12;
    chk("rst_mem_req", MEM_REQ, 0);
    chk("rst_grant", GRANT, 0);
    chk("rst_acks", {I_ACK, I_ERR, D_ACK, D_ERR}, 0);
    chk("rst_mem_bus", {MEM_WE, MEM_WSTRB, MEM_ADDR | MEM_WDATA}, 0);
    chk("rst_rdata", I_RDATA | D_RDATA, 0);
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_stall", STALL, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    // Fetch only, memory acks 2 cycles after MEM_REQ rises
    I_REQ = 1'b1; I_ADDR = 32'h0000_0010;
    step();
    chk("f_mem_req", MEM_REQ, 1);
    chk("f_grant", GRANT, 2'b01);
    chk("f_mem_addr", MEM_ADDR, 32'h10);
    chk("f_mem_we_strb", {MEM_WE, MEM_WSTRB}, 0);
    chk("f_stall", STALL, 1);
    step();
    chk("f_wait_ack", I_ACK, 0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h0050_0093;
    step();
    MEM_ACK = 1'b0;
    chk("f_i_ack", I_ACK, 1);
    chk("f_i_err", I_ERR, 0);
    chk("f_i_rdata", I_RDATA, 32'h0050_0093);
    chk("f_d_ack", D_ACK, 0);
    chk("f_mem_req_drop", MEM_REQ, 0);
    chk("f_state_resp", dbg_state, S_RESP);
    I_REQ = 1'b0;
    step();
    chk("f_ack_one_cycle", I_ACK, 0);
    chk("f_idle", dbg_state, S_IDLE);

    // Store
    D_REQ = 1'b1; D_WE = 1'b1; D_WSTRB = 4'b0011; D_ADDR = 32'h100; D_WDATA = 32'hDEAD_BEEF;
    step();
    chk("s_grant", GRANT, 2'b10);
    chk("s_mem_we", MEM_WE, 1);
    chk("s_mem_wstrb", MEM_WSTRB, 4'b0011);
    chk("s_mem_addr", MEM_ADDR, 32'h100);
    chk("s_mem_wdata", MEM_WDATA, 32'hDEAD_BEEF);
    D_ADDR = 32'h0BAD_0000; D_WDATA = 32'h1111_2222;
    step();
    chk("s_addr_held", MEM_ADDR, 32'h100);
    chk("s_wdata_held", MEM_WDATA, 32'hDEAD_BEEF);
    chk("s_req_held", MEM_REQ, 1);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h1234_5678;
    step();
    MEM_ACK = 1'b0;
    chk("s_d_ack", D_ACK, 1);
    chk("s_d_err", D_ERR, 0);
    chk("s_i_ack", I_ACK, 0);
    chk("s_d_rdata", D_RDATA, 32'h1234_5678);
    D_REQ = 1'b0; D_WE = 1'b0; D_WSTRB = '0;
    step();
    chk("s_ack_one_cycle", D_ACK, 0);

    // Contention: both held, 1-cycle memory, grants alternate every 4 cycles
    I_REQ = 1'b1; I_ADDR = 32'h200; D_REQ = 1'b1; D_ADDR = 32'h300;
    for (int t = 0; t < 8; t++) begin
      step();
      chk($sformatf("c%0d_grant", t), GRANT, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("c%0d_addr", t), MEM_ADDR, (t % 2 == 0) ? 32'h200 : 32'h300);
      step();
      MEM_ACK = 1'b1; MEM_RDATA = 32'hC000_0000 + t;
      step();
      MEM_ACK = 1'b0;
      if (t % 2 == 0) begin
        chk($sformatf("c%0d_i_ack", t), {I_ACK, D_ACK}, 2'b10);
        chk($sformatf("c%0d_i_rdata", t), I_RDATA, 32'hC000_0000 + t);
      end else begin
        chk($sformatf("c%0d_d_ack", t), {I_ACK, D_ACK}, 2'b01);
        chk($sformatf("c%0d_d_rdata", t), D_RDATA, 32'hC000_0000 + t);
      end
      if (t == 7) begin
        I_REQ = 1'b0; D_REQ = 1'b0;
      end
      step();
      chk($sformatf("c%0d_idle", t), dbg_state, S_IDLE);
    end

    // Timeout with TIMEOUT=4, memory silent
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h400;
    step();
    chk("t_mem_req", MEM_REQ, 1);
    chk("t_grant", GRANT, 2'b10);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("t_wait%0d", k), {D_ACK, MEM_REQ}, 2'b01);
    end
    step();
    chk("t_d_ack", D_ACK, 1);
    chk("t_d_err", D_ERR, 1);
    chk("t_mem_req_low", MEM_REQ, 0);
    chk("t_rdata_kept", D_RDATA, 32'hC000_0007);
    D_REQ = 1'b0;
    step();
    MEM_ACK = 1'b1; MEM_RDATA = 32'hFFFF_0000;
    step();
    MEM_ACK = 1'b0;
    chk("t_late_ack", {I_ACK, D_ACK, D_ERR, MEM_REQ}, 0);
    chk("t_late_state", dbg_state, S_IDLE);
    chk("t_late_rdata", D_RDATA, 32'hC000_0007);

    // Reset mid-grant, then re-grant of the pending fetch
    I_REQ = 1'b1; I_ADDR = 32'h20;
    step();
    chk("r_pre_grant", GRANT, 2'b01);
    #2;
    RST_N = 1'b0;
    #1;
    chk("r_async_mem_req", MEM_REQ, 0);
    chk("r_async_grant", GRANT, 0);
    chk("r_async_i_ack", I_ACK, 0);
    chk("r_async_state", dbg_state, S_IDLE);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    chk("r_regrant", GRANT, 2'b01);
    chk("r_regrant_state", dbg_state, S_GNTI);
    chk("r_regrant_addr", MEM_ADDR, 32'h20);
    step();
    MEM_ACK = 1'b1; MEM_RDATA = 32'hA5A5_A5A5;
    step();
    MEM_ACK = 1'b0;
    chk("r_i_ack", I_ACK, 1);
    chk("r_i_rdata", I_RDATA, 32'hA5A5_A5A5);
    I_REQ = 1'b0;
    step();

    // Stall with a 3-cycle memory
    D_REQ = 1'b1; D_ADDR = 32'h500;
    #1;
    chk("st_idle_stall", STALL, 1);
    step();
    chk("st_c1", STALL, 1);
    step();
    chk("st_c2", STALL, 1);
    step();
    MEM_ACK = 1'b1; MEM_RDATA = 32'h0000_5A5A;
    #1;
    chk("st_c3", STALL, 1);
    step();
    MEM_ACK = 1'b0;
    chk("st_resp_ack", D_ACK, 1);
    chk("st_resp_stall", STALL, 0);
    D_REQ = 1'b0;
    #1;
    chk("st_dropped", STALL, 0);
    step();
    chk("st_after", {STALL, D_ACK}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
